// File: rtl/spike_decoder.sv
// Windowed spike counter: counts bit[2] spikes on four neuron buses per WINDOW cycles,
// delivers counts via valid/ready. Define SPIKE_DEC_SAT_EN for saturating accumulators.
module spike_decoder #(
   parameter int WINDOW = 16,
   parameter int CW     = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [3:0]    in1,
   input  logic [3:0]    in2,
   input  logic [3:0]    in3,
   input  logic [3:0]    in4,
   output logic [CW-1:0] cnt1,
   output logic [CW-1:0] cnt2,
   output logic [CW-1:0] cnt3,
   output logic [CW-1:0] cnt4,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          overrun,
   output logic          busy
);

   localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);

   typedef enum logic {IDLE, COUNT} state_t;

   state_t          state_reg, state_next;
   logic [WW-1:0]   wcnt_reg;
   logic            out_valid_reg;
   logic            overrun_reg;
   logic [3:0]      spike;
   logic [4*CW-1:0] cnt_flat;
   logic            win_done;
   logic            load;
   logic            counting;

   assign spike    = {in4[2], in3[2], in2[2], in1[2]};
   assign counting = (state_reg == COUNT) && en;
   assign win_done = counting && (wcnt_reg == WLAST);
   // A finished window is only accepted if the output slot is free or being drained now.
   assign load     = win_done && (!out_valid_reg || out_ready);

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (en)  state_next = COUNT;
         COUNT:   if (!en) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      if (state_reg == COUNT) busy = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || !counting || win_done) wcnt_reg <= '0;
      else                              wcnt_reg <= wcnt_reg + 1'b1;
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_chan
         logic [CW-1:0] acc_reg, acc_next, cnt_reg;

         always_comb begin
`ifdef SPIKE_DEC_SAT_EN
            acc_next = acc_reg;
            if (spike[gi] && (acc_reg != {CW{1'b1}})) acc_next = acc_reg + 1'b1;
`else
            acc_next = acc_reg + CW'(spike[gi]);
`endif
         end

         always_ff @(posedge clk) begin
            if (rst || !counting || win_done) acc_reg <= '0;
            else                              acc_reg <= acc_next;
         end

         // acc_next includes the final cycle's sample of the window.
         always_ff @(posedge clk) begin
            if (rst)       cnt_reg <= '0;
            else if (load) cnt_reg <= acc_next;
         end

         assign cnt_flat[gi*CW +: CW] = cnt_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         if (load)
            out_valid_reg <= 1'b1;
         else if (out_valid_reg && out_ready)
            out_valid_reg <= 1'b0;
         if (win_done && !load)
            overrun_reg <= 1'b1;
      end
   end

   assign cnt1      = cnt_flat[0*CW +: CW];
   assign cnt2      = cnt_flat[1*CW +: CW];
   assign cnt3      = cnt_flat[2*CW +: CW];
   assign cnt4      = cnt_flat[3*CW +: CW];
   assign out_valid = out_valid_reg;
   assign overrun   = overrun_reg;

endmodule

// File: doc/spike_decoder.md
SPIKE_DECODER -- requirements
Module: spike_decoder

Interface
REQ-001 Parameter WINDOW, default 16: window length in clock cycles (legal 2..256).
REQ-002 Parameter CW, default 4: width of each spike-count output.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  decode enable; high = count windows, low = idle.
REQ-006 in1, in2, in3, in4  input  4 each  neuron state buses; a spike is bit[2] high in a sampled cycle.
REQ-007 cnt1, cnt2, cnt3, cnt4  output  CW each  spike counts of the last delivered window, one per channel.
REQ-008 out_valid  output  1  cnt1..cnt4 hold an undelivered result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 overrun  output  1  sticky: a completed window was discarded.
REQ-011 busy  output  1  high while in state COUNT.

Function
REQ-012 The FSM SHALL have two states: IDLE and COUNT.
REQ-013 In IDLE with en=1 the block SHALL enter COUNT at the next edge with window counter wcnt=0 and all accumulators at 0.
REQ-014 In COUNT, each cycle SHALL sample bit[2] of every channel; each high bit adds 1 to that channel's accumulator; wcnt increments.
REQ-015 On the cycle where wcnt=WINDOW-1, the final accumulator values, including that cycle's sample, SHALL be the window result.
REQ-016 At that cycle's edge, accumulators and wcnt SHALL restart at 0, so the next window's first sample is the next cycle (no gap cycles).
REQ-017 At that edge, if out_valid=0, or if out_valid=1 and out_ready=1, the result SHALL load into cnt1..cnt4 and out_valid SHALL be 1 in the following cycle. Latency: last sample to out_valid is 1 cycle.
REQ-018 At that edge, if out_valid=1 and out_ready=0, the result SHALL be discarded; cnt1..cnt4 SHALL be unchanged, and overrun SHALL be set.
REQ-019 When out_valid=1 and out_ready=1 with no window completing, out_valid SHALL be 0 in the next cycle. cnt1..cnt4 hold their values.
REQ-020 cnt1..cnt4 SHALL NOT change while out_valid=1, except as described in REQ-017.
REQ-021 When en=0 in COUNT, the FSM SHALL return to IDLE at that edge and discard the partial window (accumulators and wcnt cleared). out_valid, cnt1..cnt4 and overrun are preserved, and the handshake continues in IDLE.
REQ-022 Default arithmetic: accumulators are CW bits and wrap modulo 2^CW.
REQ-023 overrun SHALL be cleared only by rst.

Reset
REQ-024 Under rst=1 at a clock edge: state=IDLE, wcnt=0, accumulators=0, cnt1..cnt4=0, out_valid=0, overrun=0, busy=0.
REQ-025 rst SHALL take priority over en, out_ready and window completion; a window in progress is discarded.

Configuration
REQ-026 Macro SPIKE_DEC_SAT_EN defined: each accumulator SHALL saturate at 2^CW-1 (no wrap).
REQ-027 Macro SPIKE_DEC_SAT_EN undefined: wrap behaviour per REQ-022; all other behaviour is identical in both builds.

Verification
REQ-028 Defaults, en=1, in1[2]=1 for all 16 cycles, other inputs 0, out_ready=0 -> out_valid=1 at cycle 17 with cnt1=0 (wrap) or cnt1=15 (SAT_EN), cnt2..cnt4=0.
REQ-029 Defaults, in2[2] high on 5 cycles, in3[2] high on 3 cycles within one window, out_ready=1 -> cnt2=5, cnt3=3, out_valid high for exactly 1 cycle.
REQ-030 out_ready=0 across two window completions -> first result held, overrun=1 after the second window's edge. Then out_ready=1 -> out_valid falls and overrun stays 1.
REQ-031 out_ready=1 exactly on the completion edge of the next window -> new counts load, out_valid stays 1, overrun stays 0.
REQ-032 en dropped at wcnt=7 then raised -> no result from the partial window; the next result counts only spikes after re-entry to COUNT.
REQ-033 rst asserted at wcnt=10 with out_valid=1 -> all outputs 0 next cycle; with en held high, counting restarts at wcnt=0.
